// File: rtl/ir_edge_counter_mc_if.sv
// Avalon-MM slave bus bundle for the multi-channel IR edge counter.
interface ir_edge_counter_mc_if;
  logic [4:0]  address;
  logic [31:0] writedata;
  logic        write_n;
  logic        read_n;
  logic        chipselect;
  logic [31:0] readdata;
  logic        waitrequest;

  modport master (output address, writedata, write_n, read_n, chipselect,
                  input  readdata, waitrequest);
  modport slave  (input  address, writedata, write_n, read_n, chipselect,
                  output readdata, waitrequest);
endinterface

// File: rtl/ir_edge_counter_mc.sv
// Multi-channel IR/encoder edge counter: per-channel sync + hysteresis filter,
// edge qualify, compare/reload counting, sticky status and one registered irq.
module ir_ec_chan #(
  parameter int CNT_W    = 32,
  parameter int FILT_LEN = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_raw,
  input  logic             i_wr_ctrl,
  input  logic             i_wr_load,
  input  logic             i_wr_count,
  input  logic             i_clr_pend,
  input  logic [CNT_W-1:0] i_wdata,
  output logic [4:0]       o_ctrl,
  output logic [CNT_W-1:0] o_load,
  output logic [CNT_W-1:0] o_count,
  output logic             o_pending,
  output logic             o_level
);
  logic [1:0]          r_sync;
  logic [FILT_LEN-1:0] r_shift;
  logic                r_lvl;
  logic [4:0]          r_ctrl;
  logic [CNT_W-1:0]    r_load, r_count;
  logic                r_pend;
  logic                w_lvl, w_edge, w_qual, w_match;
  logic [CNT_W-1:0]    w_inc, w_count_nxt;

  // Level only moves on a unanimous window; r_lvl doubles as the delayed copy.
  always_comb begin
    w_lvl = r_lvl;
    if (&r_shift)       w_lvl = 1'b1;
    else if (~|r_shift) w_lvl = 1'b0;
    w_edge = w_lvl ^ r_lvl;
    case (r_ctrl[3:2])
      2'b00:   w_qual = w_edge & ~w_lvl;
      2'b01:   w_qual = w_edge &  w_lvl;
      2'b10:   w_qual = w_edge;
      default: w_qual = 1'b0;
    endcase
  end

  always_comb begin
    w_inc       = r_count + CNT_W'(1);
    w_count_nxt = r_count;
    w_match     = 1'b0;
    if (!r_ctrl[0] || i_wr_count) begin
      w_count_nxt = '0;
    end else if (w_qual) begin
      if (r_load == '0) begin
        w_count_nxt = w_inc;
      end else if (r_count == r_load && !r_ctrl[4]) begin
        w_count_nxt = r_count;
      end else if (w_inc == r_load) begin
        w_match     = 1'b1;
        w_count_nxt = r_ctrl[4] ? '0 : r_load;
      end else begin
        w_count_nxt = w_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync  <= '0;
      r_shift <= '0;
      r_lvl   <= 1'b0;
      r_ctrl  <= '0;
      r_load  <= CNT_W'(1);
      r_count <= '0;
      r_pend  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_raw};
      r_shift <= {r_shift[FILT_LEN-2:0], r_sync[1]};
      r_lvl   <= w_lvl;
      r_count <= w_count_nxt;
      if (i_wr_ctrl) r_ctrl <= i_wdata[4:0];
      if (i_wr_load) r_load <= i_wdata;
      // A match in the same cycle wins over a write-1-clear.
      if (w_match)         r_pend <= 1'b1;
      else if (i_clr_pend) r_pend <= 1'b0;
    end
  end

  assign o_ctrl    = r_ctrl;
  assign o_load    = r_load;
  assign o_count   = r_count;
  assign o_pending = r_pend;
  assign o_level   = r_lvl;
endmodule

module ir_edge_counter_mc #(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 32,
  parameter int FILT_LEN = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_CH-1:0]   in_port,
  ir_edge_counter_mc_if.slave bus,
  output logic                irq
);
  typedef enum logic {S_IDLE, S_ACK} state_t;

  state_t                         r_state, w_state_nxt;
  logic [4:0]                     r_addr;
  logic [CNT_W-1:0]               r_wdata;
  logic [31:0]                    r_rdata;
  logic                           r_is_wr, r_irq;
  logic                           w_req, w_wr_go;
  logic [31:0]                    w_rdsel;
  logic [NUM_CH-1:0][3:0][31:0]   w_rd;
  logic [NUM_CH-1:0]              w_pend_irq;

  assign w_req   = bus.chipselect & (~bus.read_n | ~bus.write_n);
  assign w_wr_go = (r_state == S_ACK) & r_is_wr;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_req) w_state_nxt = S_ACK;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Out-of-range channels fall through to the zero default.
  always_comb begin
    w_rdsel = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (bus.address[4:2] == 3'(c)) w_rdsel = w_rd[c][bus.address[1:0]];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_is_wr <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && w_req) begin
        r_addr  <= bus.address;
        r_wdata <= bus.writedata[CNT_W-1:0];
        r_is_wr <= ~bus.write_n;
        if (bus.write_n) r_rdata <= w_rdsel;
      end
      r_irq <= |w_pend_irq;
    end
  end

  genvar c;
  generate
    for (c = 0; c < NUM_CH; c++) begin : g_ch
      logic             w_sel;
      logic [4:0]       w_ctrl;
      logic [CNT_W-1:0] w_load, w_count;
      logic             w_pend, w_lvl;

      assign w_sel = w_wr_go && (r_addr[4:2] == 3'(c));

      ir_ec_chan #(.CNT_W(CNT_W), .FILT_LEN(FILT_LEN)) u_chan (
        .clk        (clk),
        .reset      (reset),
        .i_raw      (in_port[c]),
        .i_wr_ctrl  (w_sel && r_addr[1:0] == 2'd0),
        .i_wr_load  (w_sel && r_addr[1:0] == 2'd1),
        .i_wr_count (w_sel && r_addr[1:0] == 2'd2),
        .i_clr_pend (w_sel && r_addr[1:0] == 2'd3 && r_wdata[0]),
        .i_wdata    (r_wdata),
        .o_ctrl     (w_ctrl),
        .o_load     (w_load),
        .o_count    (w_count),
        .o_pending  (w_pend),
        .o_level    (w_lvl)
      );

      assign w_rd[c][0]    = {27'd0, w_ctrl};
      assign w_rd[c][1]    = 32'(w_load);
      assign w_rd[c][2]    = 32'(w_count);
      assign w_rd[c][3]    = {30'd0, w_lvl, w_pend};
      assign w_pend_irq[c] = w_pend & w_ctrl[1];
    end
  endgenerate

  assign bus.waitrequest = (r_state != S_ACK);
  assign bus.readdata    = r_rdata;
  assign irq             = r_irq;
endmodule

// File: tb/tb_ir_edge_counter_mc.sv
// Bench for ir_edge_counter_mc: directed corner cases, then random pulse trains
// scored against a run-length model of the filter and the counting rules.
module tb_ir_edge_counter_mc;
  localparam int NUM_CH   = 4;
  localparam int CNT_W    = 8;
  localparam int FILT_LEN = 6;
  localparam int CMASK    = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NUM_CH-1:0] in_port = '0;
  logic              irq;

  ir_edge_counter_mc_if bus();

  ir_edge_counter_mc #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .FILT_LEN(FILT_LEN)) dut (
    .clk     (clk),
    .reset   (reset),
    .in_port (in_port),
    .bus     (bus),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  int m_ctrl[NUM_CH];
  int m_load[NUM_CH];
  int m_cnt [NUM_CH];
  bit m_pend[NUM_CH];
  bit m_lvl [NUM_CH];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic bus_xfer(input bit wr, input logic [4:0] a, input logic [31:0] d,
                          output logic [31:0] q);
    int n = 0;
    bus.chipselect = 1'b1; bus.address = a; bus.writedata = d;
    bus.write_n = !wr; bus.read_n = wr;
    do begin @(posedge clk); #1; n++; end while (bus.waitrequest && n < 20);
    chk("ack_lat", n, 1);
    q = bus.readdata;
    bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.read_n = 1'b1;
    @(posedge clk); #1;
    chk("wait_hi", bus.waitrequest, 1);
  endtask

  task automatic wr(input int c, input int r, input logic [31:0] d);
    logic [31:0] q;
    bus_xfer(1'b1, {3'(c), 2'(r)}, d, q);
  endtask

  task automatic rdchk(input string tag, input int c, input int r, input logic [31:0] exp);
    logic [31:0] q;
    bus_xfer(1'b0, {3'(c), 2'(r)}, 32'd0, q);
    chk(tag, q, exp);
  endtask

  task automatic pulse(input int c, input int hi, input int lo);
    in_port[c] = 1'b1; tick(hi);
    in_port[c] = 1'b0; tick(lo);
  endtask

  function automatic void m_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_ctrl[c] = 0; m_load[c] = 1; m_cnt[c] = 0; m_pend[c] = 0; m_lvl[c] = 0;
    end
  endfunction

  function automatic void m_edge(input int c, input bit rise);
    int md = (m_ctrl[c] >> 2) & 3;
    bit ar = m_ctrl[c][4];
    bit q  = (md == 2) || (md == 1 && rise) || (md == 0 && !rise);
    if (!m_ctrl[c][0] || !q) return;
    if (m_load[c] == 0) m_cnt[c] = (m_cnt[c] + 1) & CMASK;
    else if (m_cnt[c] == m_load[c] && !ar) m_cnt[c] = m_cnt[c];
    else if (((m_cnt[c] + 1) & CMASK) == m_load[c]) begin
      m_pend[c] = 1'b1;
      m_cnt[c]  = ar ? 0 : m_load[c];
    end else m_cnt[c] = (m_cnt[c] + 1) & CMASK;
  endfunction

  // A run of identical raw samples flips the filtered level once it is long enough.
  function automatic void m_seg(input int c, input bit v, input int len);
    if (v != m_lvl[c] && len >= FILT_LEN) begin
      m_lvl[c] = v;
      m_edge(c, v);
    end
  endfunction

  function automatic logic m_irq();
    logic r = 1'b0;
    for (int c = 0; c < NUM_CH; c++) r |= m_pend[c] & m_ctrl[c][1];
    return r;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] q;
    bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.read_n = 1'b1;
    bus.address = '0; bus.writedata = '0;

    // reset state
    @(posedge clk); #1;
    chk("rst_wait", bus.waitrequest, 1);
    chk("rst_rdata", bus.readdata, 0);
    chk("rst_irq", irq, 0);
    reset = 1'b0;
    tick(1);
    rdchk("rst_ctrl", 0, 0, 32'h0);
    rdchk("rst_load", 0, 1, 32'h1);
    rdchk("rst_count", 0, 2, 32'h0);
    rdchk("rst_stat", 0, 3, 32'h0);

    // falling edges, saturating compare, irq
    wr(1, 0, 32'h03); wr(1, 1, 32'd5);
    repeat (5) pulse(1, 8, 10);
    rdchk("sat_cnt5", 1, 2, 32'd5);
    pulse(1, 8, 10);
    rdchk("sat_hold", 1, 2, 32'd5);
    rdchk("sat_pend", 1, 3, 32'h1);
    chk("sat_irq", irq, 1);
    wr(1, 3, 32'h1);
    chk("irq_lag", irq, 1);
    tick(1);
    chk("irq_clr", irq, 0);

    // both edges with auto-reload, irq masked
    wr(2, 0, 32'h19); wr(2, 1, 32'd4);
    repeat (3) pulse(2, 8, 10);
    rdchk("ar_cnt", 2, 2, 32'd2);
    rdchk("ar_pend", 2, 3, 32'h1);
    chk("ar_irq", irq, 0);

    // glitch rejection and step-to-edge latency
    wr(0, 0, 32'h05); wr(0, 1, 32'd0);
    repeat (3) pulse(0, 5, 10);
    rdchk("glitch", 0, 2, 32'd0);
    pulse(0, 6, 10);
    rdchk("pulse6", 0, 2, 32'd1);
    wr(0, 2, 32'd0); wr(0, 1, 32'd1); wr(0, 0, 32'h07);
    in_port[0] = 1'b1;
    tick(9);
    chk("lat_pre", irq, 0);
    tick(1);
    chk("lat_edge", irq, 1);
    in_port[0] = 1'b0;
    tick(10);
    wr(0, 3, 32'h1);
    tick(1);

    // collisions
    wr(0, 0, 32'h09); wr(0, 1, 32'd0); wr(0, 2, 32'd0);
    pulse(0, 8, 10);
    rdchk("coll_pre", 0, 2, 32'd2);
    in_port[0] = 1'b1;
    tick(7);
    wr(0, 2, 32'd0);
    tick(3);
    rdchk("coll_cnt", 0, 2, 32'd0);
    wr(0, 0, 32'h19); wr(0, 1, 32'd1); wr(0, 3, 32'h1);
    in_port[0] = 1'b0;
    tick(7);
    wr(0, 3, 32'h1);
    tick(3);
    rdchk("coll_pend", 0, 3, 32'h1);
    rdchk("coll_rld", 0, 2, 32'd0);

    // wrap with compare disabled
    wr(3, 0, 32'h09); wr(3, 1, 32'd0);
    repeat (127) pulse(3, 7, 7);
    tick(4);
    in_port[3] = 1'b1;
    tick(12);
    rdchk("wrap_max", 3, 2, 32'(CMASK));
    in_port[3] = 1'b0;
    tick(12);
    rdchk("wrap_zero", 3, 2, 32'd0);
    rdchk("wrap_stat", 3, 3, 32'd0);

    // out-of-range channel
    bus_xfer(1'b0, 5'b10100, 32'd0, q);
    chk("oor_rd", q, 0);
    bus_xfer(1'b1, 5'b10100, 32'hFF, q);
    rdchk("oor_wr", 1, 0, 32'h03);

    // reset during ACK aborts the write
    bus.chipselect = 1'b1; bus.address = {3'd1, 2'd1}; bus.writedata = 32'd9;
    bus.write_n = 1'b0; bus.read_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_ack", bus.waitrequest, 0);
    reset = 1'b1;
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_ack_wait", bus.waitrequest, 1);
    rdchk("rst_ack_load", 1, 1, 32'd1);
    rdchk("rst_ack_ctrl", 1, 0, 32'd0);
    chk("rst_ack_irq", irq, 0);
    m_reset();

    // random pulse trains, one channel per round
    for (int rnd = 0; rnd < 40; rnd++) begin
      int c, ctrl, ld, nseg;
      bit v;
      c    = $urandom_range(0, NUM_CH - 1);
      ctrl = (($urandom_range(0, 7) != 0) ? 1 : 0) | ($urandom_range(0, 1) << 1)
           | ($urandom_range(0, 3) << 2) | ($urandom_range(0, 1) << 4);
      ld   = $urandom_range(0, 6);
      wr(c, 0, 32'(ctrl)); wr(c, 1, 32'(ld)); wr(c, 2, 32'd0); wr(c, 3, 32'h1);
      m_ctrl[c] = ctrl; m_load[c] = ld; m_cnt[c] = 0; m_pend[c] = 1'b0;
      nseg = 2 * $urandom_range(2, 8) + 1;
      v = 1'b1;
      for (int s = 0; s < nseg; s++) begin
        int len = $urandom_range(1, 12);
        in_port[c] = v;
        tick(len);
        m_seg(c, v, len);
        v = !v;
      end
      in_port[c] = 1'b0;
      tick(12);
      m_seg(c, 1'b0, 12);
      tick(3);
      rdchk("rnd_cnt", c, 2, 32'(m_cnt[c]));
      rdchk("rnd_stat", c, 3, {30'd0, m_lvl[c], m_pend[c]});
      chk("rnd_irq", irq, m_irq());
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/ir_edge_counter_mc.md
Name: ir_edge_counter_mc

Overview:
Multi-channel successor to the single-channel IR pulse counter. It filters NUM_CH asynchronous IR/encoder inputs, detects qualified edges per channel with a selectable edge mode, and counts them against a per-channel compare value. Matches can auto-reload or saturate. Each channel has a sticky status flag, and one combined interrupt is raised. It is an Avalon-MM slave with waitrequest, sitting in the motor-control Qsys system beside the PWM and encoder blocks.

Parameters:
NUM_CH, 4, number of input channels (1..8)
CNT_W, 32, counter and compare width (8..32); registers are zero-extended to 32 bits on read
FILT_LEN, 6, glitch-filter depth in clk cycles (2..16)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
in_port  in  NUM_CH  raw asynchronous inputs, bit i = channel i
address  in  5  [4:2] channel, [1:0] register
writedata  in  32  write data
write_n  in  1  active-low write strobe
read_n  in  1  active-low read strobe
chipselect  in  1  slave select
readdata  out  32  read data
waitrequest  out  1  Avalon wait
irq  out  1  combined interrupt, registered

Behaviour:
- Reset: synchronous, active-high; one clk cycle with reset=1 clears everything.
  - readdata=0, waitrequest=1, irq=0.
  - All CTRL=0, LOAD=1, COUNT=0, pending=0.
  - Filter shift registers and filtered level = 0.
  - Reset mid-transfer aborts the transfer; no write commits.
- Synchroniser/filter, per channel:
  - 2-flop synchroniser feeds a FILT_LEN-deep shift register.
  - Filtered level goes to 1 only when all FILT_LEN samples are 1, and to 0 only when all are 0; otherwise it holds (hysteresis).
  - Edge = filtered level differs from its 1-cycle-delayed copy.
  - Latency from a clean input step to the edge event: 2 + FILT_LEN cycles.
- Edge mode, CTRL[3:2]: 00 falling, 01 rising, 10 both, 11 none.
- Register map, per channel (address[1:0]):
  - 0 CTRL
    - [0] enable; 0 forces COUNT=0 every cycle.
    - [1] irq_en.
    - [3:2] edge mode.
    - [4] auto_reload.
    - Remaining bits read 0.
  - 1 LOAD: compare value, CNT_W bits.
  - 2 COUNT: read returns the count; any write clears it to 0.
  - 3 STATUS
    - [0] pending (sticky); write 1 clears it.
    - [1] filtered level, read-only.
- Counting, per channel, evaluated each cycle when enable=1 and a qualified edge occurs:
  - LOAD=0: compare disabled; COUNT increments mod 2^CNT_W.
  - COUNT==LOAD with auto_reload=0: saturated; edge ignored, COUNT holds.
  - COUNT+1==LOAD: pending<=1; COUNT <= auto_reload ? 0 : LOAD.
  - Otherwise: COUNT <= COUNT+1.
- Simultaneous events:
  - COUNT-clear write or enable=0 beats an edge in the same cycle.
  - A new match beats a STATUS write-1-clear in the same cycle (pending stays 1).
  - A LOAD write takes effect for edges from the next cycle onward.
  - If COUNT > new LOAD, no match occurs until COUNT wraps.
- irq <= OR over channels of (pending & irq_en), registered with 1-cycle latency. It deasserts the cycle after the last contributing pending is cleared or irq_en drops.
- Bus handshake, 2-state FSM (IDLE/ACK):
  - IDLE: if chipselect & (~read_n | ~write_n), go to ACK; waitrequest stays 1.
  - ACK: waitrequest=0 for exactly one cycle.
    - A write commits at the end of this cycle.
    - readdata is valid during this cycle (sampled from register state at the end of the IDLE cycle).
    - Then return to IDLE with waitrequest=1, even if the request is still held; a held request starts a new transfer.
  - read_n and write_n both low: treated as a write.
- Address decode:
  - Channel index >= NUM_CH: reads return 0, writes are ignored, handshake still completes.
  - readdata holds its last value outside ACK.

Test Plan:
1. Reset, then read ch0 CTRL/LOAD/COUNT/STATUS -> 0x0/0x1/0x0/0x0; waitrequest low for exactly 1 cycle per access; irq=0.
2. Ch1 CTRL=0x03 (enable, irq_en, falling), LOAD=5; apply 5 clean pulses -> COUNT=5 and holds through a 6th pulse; STATUS[0]=1; irq=1 one cycle after the pending set; write STATUS=1 -> irq=0.
3. Ch2 CTRL=0x19 (enable, both edges, auto_reload), LOAD=4; apply 3 pulses (6 edges) -> match after the 4th edge; COUNT=2 at end; pending=1; irq stays 0 (irq_en=0).
4. Glitch rejection with FILT_LEN=6: ch0 high pulses of 5 cycles -> COUNT unchanged; a 6-cycle pulse -> COUNT +1, with the edge 8 cycles after the input step.
5. Collisions: COUNT write on the same cycle as an edge -> COUNT=0; STATUS clear on the same cycle as a match -> pending=1; LOAD=0 with COUNT=0xFFFFFFFF and one edge -> COUNT=0, no pending.
6. Out-of-range channel (NUM_CH=4, address 5'b10100) -> read 0, write has no effect; assert reset mid-ACK -> waitrequest=1 and no register change.
